// File: rtl/fpga_io_pkg.sv
// Shared constants for the board I/O panel: key indices, blank pattern and the
// active-low gfedcba hex segment table.
package fpga_io_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int unsigned KEY_RST    = 0;
  localparam int unsigned KEY_NEXT   = 1;
  localparam int unsigned KEY_PREV   = 2;
  localparam int unsigned KEY_FREEZE = 3;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/fpga_io_panel_key_debouncer.sv
// Two-flop synchroniser plus stable-state debouncer for one active-low key.
// press_o pulses for one cycle, in the same cycle the stable state flips to pressed.
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_ni,
  output logic pressed_o,
  output logic press_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flip;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    flip     = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        flip     = 1'b1;
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // stable_q is active-low: a flip while it is 1 is a press
  assign press_o   = flip & stable_q;
  assign pressed_o = ~stable_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= key_ni;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/fpga_io_panel.sv
// Board I/O front end: key debounce, CPU reset, switch input and paged hex display.
// Define LEADING_ZERO_BLANK_EN to blank digits above the most significant nonzero digit.
module fpga_io_panel
  import fpga_io_pkg::*;
#(
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned N_CH            = 4,
  parameter int unsigned N_DIGITS        = 4,
  parameter int unsigned SW_W            = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                key_n,
  input  logic [SW_W-1:0]           sw,
  input  logic [N_CH*DATA_W-1:0]    ch_data,
  output logic                      cpu_reset,
  output logic [DATA_W-1:0]         cpu_input,
  output logic [SW_W-1:0]           ledr,
  output logic [7*N_DIGITS-1:0]     hex_seg,
  output logic [6:0]                hex_page,
  output logic [$clog2(N_CH)-1:0]   page,
  output logic                      frozen
);

  localparam int unsigned PAGE_W = $clog2(N_CH);
  localparam int unsigned DISP_W = 4 * N_DIGITS;
  localparam logic [PAGE_W-1:0] PAGE_MAX = PAGE_W'(N_CH - 1);

  function automatic logic [7*N_DIGITS-1:0] decode_digits(input logic [DISP_W-1:0] v);
    logic [7*N_DIGITS-1:0] seg;
`ifdef LEADING_ZERO_BLANK_EN
    logic nz;
    nz = 1'b0;
`endif
    seg = '0;
    for (int d = int'(N_DIGITS) - 1; d >= 0; d--) begin
`ifdef LEADING_ZERO_BLANK_EN
      nz = nz | (v[4*d +: 4] != 4'h0);
      seg[7*d +: 7] = (nz || d == 0) ? hex7(v[4*d +: 4]) : SEG_BLANK;
`else
      seg[7*d +: 7] = hex7(v[4*d +: 4]);
`endif
    end
    return seg;
  endfunction

  localparam logic [7*N_DIGITS-1:0] SEG_RST = decode_digits('0);

  logic [3:0] press, pressed;

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_i    (clk),
      .rst_i    (reset),
      .key_ni   (key_n[k]),
      .pressed_o(pressed[k]),
      .press_o  (press[k])
    );
  end

  logic unused_keys;
  assign unused_keys = ^{pressed[3:1], press[KEY_RST]};

  logic [SW_W-1:0]          sw_s1_q, sw_s2_q, sw_q;
  logic                     cpu_reset_q;
  logic [PAGE_W-1:0]        page_q, page_d;
  logic                     frozen_q, frozen_d;
  logic                     reload_q, reload_d;
  logic [DATA_W-1:0]        disp_q, disp_d, sel_ch;
  logic [7*N_DIGITS-1:0]    seg_q, seg_d;
  logic [6:0]               page_seg_q, page_seg_d;

  always_comb begin
    page_d = page_q;
    if (press[KEY_NEXT] && !press[KEY_PREV]) begin
      page_d = (page_q == PAGE_MAX) ? '0 : page_q + 1'b1;
    end else if (press[KEY_PREV] && !press[KEY_NEXT]) begin
      page_d = (page_q == '0) ? PAGE_MAX : page_q - 1'b1;
    end
    frozen_d = frozen_q ^ press[KEY_FREEZE];
    // A page change while frozen refreshes the snapshot once, one cycle later
    reload_d = (page_d != page_q);
    sel_ch   = ch_data[32'(page_q) * DATA_W +: DATA_W];
    disp_d   = (!frozen_q || reload_q) ? sel_ch : disp_q;
    seg_d      = decode_digits(DISP_W'(disp_q));
    page_seg_d = hex7(4'(page_q));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_s1_q     <= '0;
      sw_s2_q     <= '0;
      sw_q        <= '0;
      cpu_reset_q <= 1'b1;
      page_q      <= '0;
      frozen_q    <= 1'b0;
      reload_q    <= 1'b0;
      disp_q      <= '0;
      seg_q       <= SEG_RST;
      page_seg_q  <= 7'h40;
    end else begin
      sw_s1_q     <= sw;
      sw_s2_q     <= sw_s1_q;
      sw_q        <= sw_s2_q;
      cpu_reset_q <= pressed[KEY_RST];
      page_q      <= page_d;
      frozen_q    <= frozen_d;
      reload_q    <= reload_d;
      disp_q      <= disp_d;
      seg_q       <= seg_d;
      page_seg_q  <= page_seg_d;
    end
  end

  assign cpu_reset = cpu_reset_q;
  assign cpu_input = DATA_W'($signed(sw_q));
  assign ledr      = sw_q;
  assign hex_seg   = seg_q;
  assign hex_page  = page_seg_q;
  assign page      = page_q;
  assign frozen    = frozen_q;

endmodule

// File: tb/tb_fpga_io_panel.sv
// Self-checking bench for fpga_io_panel with DEBOUNCE_CYCLES=4 and randomized data.
module tb_fpga_io_panel;

  localparam int DATA_W = 16;
  localparam int N_CH = 4;
  localparam int N_DIGITS = 4;
  localparam int SW_W = 10;
  localparam int DEB = 4;
  localparam logic [6:0] SEG_TBL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02,
    7'h78, 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [3:0]             key_n = 4'hF;
  logic [SW_W-1:0]        sw = '0;
  logic [N_CH*DATA_W-1:0] ch_data = '0;
  logic                   cpu_reset;
  logic [DATA_W-1:0]      cpu_input;
  logic [SW_W-1:0]        ledr;
  logic [7*N_DIGITS-1:0]  hex_seg;
  logic [6:0]             hex_page;
  logic [1:0]             page;
  logic                   frozen;

  int n_vec = 0;
  int n_err = 0;
  int page_m = 0;
  logic frozen_m = 1'b0;
  logic [SW_W-1:0] sw_m = '0;

  fpga_io_panel #(
    .DATA_W(DATA_W), .N_CH(N_CH), .N_DIGITS(N_DIGITS), .SW_W(SW_W), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .sw(sw), .ch_data(ch_data),
    .cpu_reset(cpu_reset), .cpu_input(cpu_input), .ledr(ledr), .hex_seg(hex_seg),
    .hex_page(hex_page), .page(page), .frozen(frozen)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] exp_seg(input logic [15:0] v);
    logic [27:0] s;
    s = '0;
    for (int d = 0; d < 4; d++) begin
      s[7*d +: 7] = SEG_TBL[int'((v >> (4*d)) & 16'hF)];
`ifdef LEADING_ZERO_BLANK_EN
      if (d > 0 && (v >> (4*d)) == 16'h0) s[7*d +: 7] = 7'h7F;
`endif
    end
    return s;
  endfunction

  function automatic logic [15:0] exp_cpu(input logic [SW_W-1:0] v);
    if (int'(v) >= 512) return 16'(int'(v) - 1024 + 65536);
    return 16'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] mask);
    key_n = ~mask;
    repeat (10) tick();
    key_n = 4'hF;
    repeat (10) tick();
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_vec++; if (cpu_reset !== 1'b1) begin n_err++; $display("FAIL rst_cpu_reset got %0b want 1", cpu_reset); end
    n_vec++; if (page !== 2'd0) begin n_err++; $display("FAIL rst_page got %0d want 0", page); end
    n_vec++; if (frozen !== 1'b0) begin n_err++; $display("FAIL rst_frozen got %0b want 0", frozen); end
    n_vec++; if (hex_seg !== exp_seg(16'h0)) begin n_err++; $display("FAIL rst_hex_seg got %h want %h", hex_seg, exp_seg(16'h0)); end
    n_vec++; if (hex_page !== 7'h40) begin n_err++; $display("FAIL rst_hex_page got %h want 40", hex_page); end
    n_vec++; if (cpu_input !== 16'h0 || ledr !== 10'h0) begin n_err++; $display("FAIL rst_sw got %h/%h want 0/0", cpu_input, ledr); end
    reset = 1'b0;
    repeat (3) tick();
    n_vec++; if (cpu_reset !== 1'b0) begin n_err++; $display("FAIL rst_release got %0b want 0", cpu_reset); end
  endtask

  task automatic test_switches();
    logic [SW_W-1:0] list [4];
    logic [SW_W-1:0] v, prev;
    list = '{10'h3FF, 10'h1FF, 10'h200, 10'h000};
    for (int i = 0; i < 10; i++) begin
      v = (i < 4) ? list[i] : SW_W'($urandom);
      prev = sw_m;
      sw = v;
      repeat (2) tick();
      if (exp_cpu(v) != exp_cpu(prev)) begin
        n_vec++; if (cpu_input !== exp_cpu(prev)) begin n_err++; $display("FAIL sw_latency got %h want %h", cpu_input, exp_cpu(prev)); end
      end
      tick();
      sw_m = v;
      n_vec++; if (cpu_input !== exp_cpu(v)) begin n_err++; $display("FAIL sw_cpu_input sw=%h got %h want %h", v, cpu_input, exp_cpu(v)); end
      n_vec++; if (ledr !== v) begin n_err++; $display("FAIL sw_ledr got %h want %h", ledr, v); end
    end
  endtask

  task automatic test_debounce();
    key_n[1] = 1'b0;
    repeat (3) tick();
    key_n[1] = 1'b1;
    repeat (10) tick();
    n_vec++; if (page !== 2'(page_m)) begin n_err++; $display("FAIL deb_glitch page got %0d want %0d", page, page_m); end
    key_n[1] = 1'b0;
    repeat (5) tick();
    n_vec++; if (page !== 2'(page_m)) begin n_err++; $display("FAIL deb_early page got %0d want %0d", page, page_m); end
    tick();
    page_m = (page_m + 1) % N_CH;
    n_vec++; if (page !== 2'(page_m)) begin n_err++; $display("FAIL deb_edge page got %0d want %0d", page, page_m); end
    repeat (4) tick();
    key_n[1] = 1'b1;
    repeat (10) tick();
    n_vec++; if (page !== 2'(page_m)) begin n_err++; $display("FAIL deb_single page got %0d want %0d", page, page_m); end
  endtask

  task automatic goto_page0();
    for (int i = 0; i < N_CH && page_m != 0; i++) begin
      press(4'b0010);
      page_m = (page_m + 1) % N_CH;
    end
  endtask

  task automatic test_page_wrap();
    goto_page0();
    for (int i = 0; i < 4; i++) begin
      press(4'b0010);
      page_m = (page_m + 1) % N_CH;
      n_vec++; if (page !== 2'(page_m)) begin n_err++; $display("FAIL wrap_next page got %0d want %0d", page, page_m); end
      n_vec++; if (hex_page !== SEG_TBL[page_m]) begin n_err++; $display("FAIL wrap_hex_page got %h want %h", hex_page, SEG_TBL[page_m]); end
    end
    press(4'b0100);
    page_m = (page_m + N_CH - 1) % N_CH;
    n_vec++; if (page !== 2'(page_m)) begin n_err++; $display("FAIL wrap_prev page got %0d want %0d", page, page_m); end
    press(4'b0110);
    n_vec++; if (page !== 2'(page_m)) begin n_err++; $display("FAIL wrap_both page got %0d want %0d", page, page_m); end
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        press(4'b0010);
        page_m = (page_m + 1) % N_CH;
      end else begin
        press(4'b0100);
        page_m = (page_m + N_CH - 1) % N_CH;
      end
      n_vec++; if (page !== 2'(page_m)) begin n_err++; $display("FAIL walk page got %0d want %0d", page, page_m); end
    end
  endtask

  task automatic test_display();
    logic [15:0] v, old;
    for (int i = 0; i < 10; i++) begin
      old = ch_data[page_m*16 +: 16];
      for (int c = 0; c < N_CH; c++) ch_data[c*16 +: 16] = 16'($urandom);
      if (i == 0) ch_data[page_m*16 +: 16] = 16'h00F0;
      if (i == 1) ch_data[page_m*16 +: 16] = 16'h0000;
      v = ch_data[page_m*16 +: 16];
      tick();
      if (exp_seg(v) != exp_seg(old)) begin
        n_vec++; if (hex_seg !== exp_seg(old)) begin n_err++; $display("FAIL disp_latency got %h want %h", hex_seg, exp_seg(old)); end
      end
      tick();
      n_vec++; if (hex_seg !== exp_seg(v)) begin n_err++; $display("FAIL disp_value ch=%h got %h want %h", v, hex_seg, exp_seg(v)); end
    end
  endtask

  task automatic test_freeze();
    goto_page0();
    ch_data[15:0] = 16'h1234;
    repeat (3) tick();
    press(4'b1000);
    frozen_m = 1'b1;
    n_vec++; if (frozen !== frozen_m) begin n_err++; $display("FAIL frz_on got %0b want 1", frozen); end
    ch_data[15:0] = 16'hABCD;
    repeat (3) tick();
    n_vec++; if (hex_seg !== exp_seg(16'h1234)) begin n_err++; $display("FAIL frz_hold got %h want %h", hex_seg, exp_seg(16'h1234)); end
    ch_data[31:16] = 16'h00F0;
    press(4'b0010);
    page_m = 1;
    n_vec++; if (page !== 2'd1 || frozen !== 1'b1) begin n_err++; $display("FAIL frz_page got %0d/%0b want 1/1", page, frozen); end
    n_vec++; if (hex_seg !== exp_seg(16'h00F0)) begin n_err++; $display("FAIL frz_reload got %h want %h", hex_seg, exp_seg(16'h00F0)); end
    ch_data[31:16] = 16'h5555;
    repeat (3) tick();
    n_vec++; if (hex_seg !== exp_seg(16'h00F0)) begin n_err++; $display("FAIL frz_hold2 got %h want %h", hex_seg, exp_seg(16'h00F0)); end
    press(4'b1000);
    frozen_m = 1'b0;
    n_vec++; if (frozen !== 1'b0 || hex_seg !== exp_seg(16'h5555)) begin n_err++; $display("FAIL frz_off got %0b/%h want 0/%h", frozen, hex_seg, exp_seg(16'h5555)); end
  endtask

  task automatic test_cpu_reset_key();
    press(4'b0010);
    page_m = (page_m + 1) % N_CH;
    press(4'b1000);
    frozen_m = 1'b1;
    key_n[0] = 1'b0;
    repeat (6) tick();
    n_vec++; if (cpu_reset !== 1'b0) begin n_err++; $display("FAIL key0_early got %0b want 0", cpu_reset); end
    repeat (2) tick();
    n_vec++; if (cpu_reset !== 1'b1) begin n_err++; $display("FAIL key0_held got %0b want 1", cpu_reset); end
    repeat (2) tick();
    key_n[0] = 1'b1;
    repeat (10) tick();
    n_vec++; if (cpu_reset !== 1'b0) begin n_err++; $display("FAIL key0_release got %0b want 0", cpu_reset); end
    n_vec++; if (page !== 2'(page_m) || frozen !== frozen_m) begin n_err++; $display("FAIL key0_keep got %0d/%0b want %0d/%0b", page, frozen, page_m, frozen_m); end
  endtask

  task automatic test_reset_mid();
    sw = 10'h2AA;
    repeat (4) tick();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_vec++; if (cpu_reset !== 1'b1) begin n_err++; $display("FAIL mid_cpu_reset got %0b want 1", cpu_reset); end
    n_vec++; if (page !== 2'd0 || frozen !== 1'b0) begin n_err++; $display("FAIL mid_state got %0d/%0b want 0/0", page, frozen); end
    n_vec++; if (hex_seg !== exp_seg(16'h0) || hex_page !== 7'h40) begin n_err++; $display("FAIL mid_hex got %h/%h want %h/40", hex_seg, hex_page, exp_seg(16'h0)); end
    n_vec++; if (cpu_input !== 16'h0) begin n_err++; $display("FAIL mid_cpu_input got %h want 0", cpu_input); end
    tick();
    reset = 1'b0;
    page_m = 0;
    frozen_m = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_switches();
    test_debounce();
    test_page_wrap();
    test_display();
    test_freeze();
    test_cpu_reset_key();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fpga_io_panel.md
Name: fpga_io_panel

Overview:
- Parametrised board I/O front end for the CPU FPGA top level. It replaces the hard-wired switch, key and hex-display glue.
- Synchronises and debounces push keys, derives the CPU reset, and sign-extends the switches into the CPU input word.
- Multiplexes N_CH CPU observation channels onto the 7-segment digits, with next/previous page select and a freeze (snapshot) mode.

Parameters:
- DATA_W, 16, width of each channel and of cpu_input; DATA_W <= 4*N_DIGITS.
- N_CH, 4, number of observable channels (>= 2).
- N_DIGITS, 4, number of hex data digits.
- SW_W, 10, number of slide switches; SW_W <= DATA_W.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a key change (>= 2).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- key_n, input, 4, raw push keys, active-low (0 = pressed): [0] cpu reset, [1] next page, [2] previous page, [3] freeze toggle.
- sw, input, SW_W, raw slide switches.
- ch_data, input, N_CH*DATA_W, channel c occupies bits [c*DATA_W +: DATA_W].
- cpu_reset, output, 1, active-high reset to the CPU.
- cpu_input, output, DATA_W, synchronised sw, sign-extended from sw[SW_W-1].
- ledr, output, SW_W, synchronised sw mirror.
- hex_seg, output, 7*N_DIGITS, active-low segments; digit d at [7*d +: 7], gfedcba order.
- hex_page, output, 7, active-low segments showing the page number.
- page, output, clog2(N_CH), current channel index.
- frozen, output, 1, freeze mode active.

Behaviour:
- Synchronisers:
  - Two-flop synchronisers on key_n and sw.
  - key_n synchroniser stages reset to 1 (released); sw stages reset to 0.
- Debounce (per key):
  - Holds a stable state (reset = released) and a counter (reset = 0).
  - Counter clears whenever the synchronised sample equals the stable state; otherwise it increments.
  - On reaching DEBOUNCE_CYCLES-1 while still differing, the stable state flips and the counter clears.
  - A one-cycle press pulse fires on a released->pressed flip; there is no pulse on release.
  - Raw edge to pulse latency: 2 + DEBOUNCE_CYCLES clocks. A glitch shorter than DEBOUNCE_CYCLES cycles has no effect.
- cpu_reset:
  - Registered; equals reset OR debounced key0 pressed.
  - Reset value 1; it stays high for the whole key hold.
- cpu_input / ledr:
  - Registered from the synchronised sw; reset value 0.
  - Latency sw -> outputs is 3 clocks.
- Page counter:
  - Reset value 0.
  - Next pulse: page+1, wrapping N_CH-1 -> 0.
  - Prev pulse: page-1, wrapping 0 -> N_CH-1.
  - Next and prev pulse in the same cycle: no change.
- Freeze:
  - Key3 pulse toggles frozen; reset value 0.
  - When not frozen, disp_reg loads the selected channel every cycle.
  - When frozen, disp_reg holds its value, except that a page change while frozen reloads disp_reg once from the new channel, in the cycle after the page update.
  - The freeze toggle and a page change in the same cycle are both applied.
  - cpu_reset does not clear page or frozen; only reset does.
- Display:
  - disp_reg is DATA_W wide, reset 0, zero-extended to 4*N_DIGITS bits.
  - Segment outputs are registered from the hex decode of disp_reg.
  - ch_data to hex_seg latency: 2 clocks when not frozen.
  - hex_page shows the page value (mod 16) with 1-cycle latency.
- Reset values:
  - Every hex_seg digit and hex_page = 7'b1000000 ("0").
  - page = 0, frozen = 0.
- Hex table, active-low, values 0-F: 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Any digit above the most significant nonzero digit outputs blank (7'b1111111).
  - Digit 0 is always shown.
  - Reset value: digit 0 = "0", all other digits blank.
  - Decode is still registered; latency is unchanged.
- Undefined: all N_DIGITS digits are always shown, including leading zeros.

Decomposition:
- Package fpga_io_pkg:
  - SEG_BLANK constant and the 16-entry active-low hex segment table or a function.
  - Key index constants (KEY_RST, KEY_NEXT, KEY_PREV, KEY_FREEZE).
- Sub-module key_debouncer:
  - Parametrised by DEBOUNCE_CYCLES.
  - Contains the synchroniser, counter, stable state and press pulse.
  - Instantiated 4 times.

Test Plan (DEBOUNCE_CYCLES=4, N_CH=4, DATA_W=16, N_DIGITS=4):
- Reset:
  - Assert reset mid-operation with page=2 and frozen=1.
  - Required: cpu_reset=1 immediately; page=0, frozen=0, all digits 0x40, cpu_input=0.
- Switch sign extension:
  - sw=10'h3FF -> cpu_input=16'hFFFF after 3 clocks.
  - sw=10'h1FF -> cpu_input=16'h01FF, ledr=10'h1FF.
- Debounce:
  - key_n[1] low for 3 cycles, then high -> page stays 0.
  - Held low for 10 cycles -> page=1 exactly 6 clocks after the edge, with a single increment.
- Page wrap:
  - 4 next presses -> page 0,1,2,3,0.
  - Prev from 0 -> page=3.
  - Next and prev pulses forced in the same cycle -> page unchanged.
- Freeze:
  - ch0=16'h1234, press key3, then set ch0=16'hABCD -> digits remain 1,2,3,4.
  - Press next with ch1=16'h00F0 -> digits show 0,0,F,0 while frozen stays 1.
- Leading-zero blanking (with LEADING_ZERO_BLANK_EN):
  - ch0=16'h00F0 -> digits [3:0] = 7F,7F,0E,40.
  - ch0=0 -> 7F,7F,7F,40.
  - Without the macro, ch0=16'h00F0 -> 40,40,0E,40.
